btb_update_queue: RTL and testbench

Write-side companion of the BTB: consumes `BranchResult` records from the integer back end, converts each taken branch into a `BTB_Entry`, and buffers it in a circular queue. Entries drain into the BTB's single write port whenever the fetch-side read does not claim the array that cycle. It sits between the branch-resolution path and the BTB array, mirroring the prediction path that produces `BranchPred`.

---
 rtl/FetchUnitTypes.sv | 56 +++++
 rtl/btb_update_fifo.sv | 51 +++++
 rtl/btb_update_queue.sv | 91 +++++++++
 tb/tb_btb_update_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/FetchUnitTypes.sv
// FetchUnitTypes: shared fetch-unit types for the BTB prediction and update
// paths. Holds the BTB geometry, the address-to-index/tag/target conversion
// functions, the branch-resolution record and the update-queue entry types.
package FetchUnitTypes;

  localparam int ADDR_WIDTH                = 32;
  localparam int INSN_BYTE_WIDTH_BIT       = 2;   // 4-byte instructions
  localparam int BTB_ENTRY_NUM_BIT         = 9;   // 512-entry BTB
  localparam int BTB_TAG_WIDTH             = 4;
  localparam int BTB_CONTRACTED_ADDR_WIDTH = 18;
  localparam int BTB_QUEUE_SIZE            = 32;

  typedef logic [ADDR_WIDTH-1:0]                AddrPath;
  typedef logic [BTB_ENTRY_NUM_BIT-1:0]         BTB_IndexPath;
  typedef logic [BTB_TAG_WIDTH-1:0]             BTB_TagPath;
  typedef logic [BTB_CONTRACTED_ADDR_WIDTH-1:0] BTB_AddrPath;
  typedef logic [$clog2(BTB_QUEUE_SIZE)-1:0]    BTBQueuePointerPath;
  typedef logic [$clog2(BTB_QUEUE_SIZE):0]      BTBQueueCountPath;

  typedef struct packed {
    logic        valid;
    BTB_TagPath  tag;
    BTB_AddrPath data;
    logic        isCondBr;
    logic        isRASPushBr;
    logic        isRASPopBr;
  } BTB_Entry;

  typedef struct packed {
    AddrPath  wa;   // full branch address; indexed only when written out
    BTB_Entry wv;
  } BTBQueueEntry;

  typedef struct packed {
    logic    valid;
    AddrPath brAddr;
    AddrPath nextAddr;
    logic    execTaken;
    logic    isCondBr;
    logic    isRASPushBr;
    logic    isRASPopBr;
  } BranchResult;

  function automatic BTB_IndexPath ToBTB_Index(input AddrPath addr);
    return addr[INSN_BYTE_WIDTH_BIT +: BTB_ENTRY_NUM_BIT];
  endfunction

  function automatic BTB_TagPath ToBTB_Tag(input AddrPath addr);
    return addr[INSN_BYTE_WIDTH_BIT + BTB_ENTRY_NUM_BIT +: BTB_TAG_WIDTH];
  endfunction

  function automatic BTB_AddrPath ToBTB_Addr(input AddrPath addr);
    return addr[INSN_BYTE_WIDTH_BIT +: BTB_CONTRACTED_ADDR_WIDTH];
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// btb_update_fifo: generic circular FIFO with separately tracked count.
//   clk, rst      : clock, async active-high reset (pointers/count only)
//   push/pushData : write pushData at tail
//   pop           : advance head
//   headData      : contents of the head slot (always driven)
//   count         : occupied entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointers wrap by plain overflow.
// The caller must not push when full unless it pops in the same cycle.
module btb_update_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Storage is intentionally not reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= pushData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign headData = mem[head];

endmodule

// File: rtl/btb_update_queue.sv
// btb_update_queue: write-side companion of the BTB. Turns each resolved
// taken branch into a BTB entry, buffers it, and drains one entry per cycle
// into the BTB write port whenever the fetch read does not hold the array.
//   clk, rst     : clock, async active-high reset
//   brResult     : resolved branch record from execute
//   btbReadBusy  : fetch is reading the BTB; write port unavailable
//   btbWE/WA/WV  : BTB write enable / index / entry
//   queueCount   : occupied entries
//   queueFull    : queueCount == QUEUE_SIZE
//   dropped      : eligible result discarded because the queue was full
// Optional: RSD_BTB_UPDATE_BYPASS_EN writes straight through to the BTB when
// the queue is empty and the port is free.
module btb_update_queue
  import FetchUnitTypes::*;
#(
  parameter int QUEUE_SIZE = BTB_QUEUE_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  BranchResult                   brResult,
  input  logic                          btbReadBusy,
  output logic                          btbWE,
  output BTB_IndexPath                  btbWA,
  output BTB_Entry                      btbWV,
  output logic [$clog2(QUEUE_SIZE):0]   queueCount,
  output logic                          queueFull,
  output logic                          dropped
);

  localparam int CNT_W = $clog2(QUEUE_SIZE) + 1;
  localparam int ENT_W = $bits(BTBQueueEntry);

  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] headRaw;
  BTBQueueEntry     head;
  BTBQueueEntry     newEntry;
  logic             eligible;
  logic             isFull;
  logic             deq;
  logic             enq;
  logic             bypass;

  assign eligible = brResult.valid && brResult.execTaken;
  assign isFull   = (count == CNT_W'(QUEUE_SIZE));
  assign deq      = (count != '0) && !btbReadBusy;

`ifdef RSD_BTB_UPDATE_BYPASS_EN
  assign bypass = eligible && (count == '0) && !btbReadBusy;
`else
  assign bypass = 1'b0;
`endif

  // A slot frees up at the same edge when the head drains, so a full queue
  // can still accept.
  assign enq     = eligible && !bypass && (!isFull || deq);
  assign dropped = eligible && isFull && !deq;

  always_comb begin
    newEntry                = '0;
    newEntry.wa             = brResult.brAddr;
    newEntry.wv.valid       = 1'b1;
    newEntry.wv.tag         = ToBTB_Tag(brResult.brAddr);
    newEntry.wv.data        = ToBTB_Addr(brResult.nextAddr);
    newEntry.wv.isCondBr    = brResult.isCondBr;
    newEntry.wv.isRASPushBr = brResult.isRASPushBr;
    newEntry.wv.isRASPopBr  = brResult.isRASPopBr;
  end

  btb_update_fifo #(
    .DEPTH (QUEUE_SIZE),
    .WIDTH (ENT_W)
  ) fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (enq),
    .pushData (newEntry),
    .pop      (deq),
    .headData (headRaw),
    .count    (count)
  );

  assign head = BTBQueueEntry'(headRaw);

  // Reset clears count asynchronously, so btbWE drops without a clock edge.
  assign btbWE      = deq || bypass;
  assign btbWA      = bypass ? ToBTB_Index(newEntry.wa) : ToBTB_Index(head.wa);
  assign btbWV      = bypass ? newEntry.wv : head.wv;
  assign queueCount = count;
  assign queueFull  = isFull;

endmodule

// File: tb/tb_btb_update_queue.sv
module tb_btb_update_queue;
  import FetchUnitTypes::*;

  localparam int QS = 32;

  logic        clk = 1'b0;
  logic        rst;
  BranchResult brResult;
  logic        btbReadBusy;
  logic        btbWE;
  BTB_IndexPath btbWA;
  BTB_Entry    btbWV;
  logic [5:0]  queueCount;
  logic        queueFull;
  logic        dropped;

  btb_update_queue #(.QUEUE_SIZE(QS)) dut (
    .clk         (clk),
    .rst         (rst),
    .brResult    (brResult),
    .btbReadBusy (btbReadBusy),
    .btbWE       (btbWE),
    .btbWA       (btbWA),
    .btbWV       (btbWV),
    .queueCount  (queueCount),
    .queueFull   (queueFull),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ba;
    logic [31:0] na;
    logic [2:0]  fl;
  } ref_t;

  ref_t mq[$];
  int   nTests = 0;
  int   nFail  = 0;
  int   dutDrops = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expIndex(input logic [31:0] a);
    return 64'((a >> 2) % 512);
  endfunction

  // Expected BTB word: valid, 4-bit tag, 18-bit target, cond/push/pop flags.
  function automatic logic [63:0] expWV(input ref_t e);
    logic [31:0] tg;
    logic [31:0] dt;
    tg = (e.ba >> 11) % 16;
    dt = (e.na >> 2) % (1 << 18);
    return 64'(1) * (2**25) + 64'(tg) * (2**21) + 64'(dt) * 8 + 64'(e.fl);
  endfunction

  // Drive one cycle, check combinational outputs at the falling edge,
  // advance the reference queue, then move past the rising edge.
  task automatic step(input logic v, input logic tk, input logic [31:0] ba,
                      input logic [31:0] na, input logic [2:0] fl, input logic busy);
    int   cnt;
    logic elig, deq, byp, expDrop;
    ref_t cur;
    brResult.valid       = v;
    brResult.execTaken   = tk;
    brResult.brAddr      = ba;
    brResult.nextAddr    = na;
    brResult.isCondBr    = fl[2];
    brResult.isRASPushBr = fl[1];
    brResult.isRASPopBr  = fl[0];
    btbReadBusy          = busy;
    cur.ba = ba; cur.na = na; cur.fl = fl;
    @(negedge clk);
    cnt  = mq.size();
    elig = v && tk;
    deq  = (cnt > 0) && !busy;
    byp  = 1'b0;
`ifdef RSD_BTB_UPDATE_BYPASS_EN
    byp  = elig && (cnt == 0) && !busy;
`endif
    expDrop = elig && (cnt == QS) && !deq;
    check("we", 64'(btbWE), 64'(deq || byp));
    check("count", 64'(queueCount), 64'(cnt));
    check("full", 64'(queueFull), 64'(cnt == QS));
    check("dropped", 64'(dropped), 64'(expDrop));
    if (dropped) dutDrops++;
    if (deq) begin
      check("wa", 64'(btbWA), expIndex(mq[0].ba));
      check("wv", 64'(btbWV), expWV(mq[0]));
      void'(mq.pop_front());
    end else if (byp) begin
      check("wa_byp", 64'(btbWA), expIndex(ba));
      check("wv_byp", 64'(btbWV), expWV(cur));
    end
    if (elig && !byp && mq.size() < QS) mq.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    brResult = '0;
    btbReadBusy = 1'b0;
    #1;
    check("rst_we", 64'(btbWE), 64'(0));
    check("rst_count", 64'(queueCount), 64'(0));
    check("rst_full", 64'(queueFull), 64'(0));
    check("rst_dropped", 64'(dropped), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single taken branch, then idle so it drains.
    step(1, 1, 32'h1000, 32'h2000, 3'b100, 0);
    step(0, 0, 32'h0, 32'h0, 3'b000, 0);
    step(0, 0, 32'h0, 32'h0, 3'b000, 0);

    // Not-taken / invalid results are ignored.
    for (int i = 0; i < 10; i++)
      step(i % 2 == 0, i % 2 == 1, 32'h3000 + 32'(i * 4), $urandom, 3'($urandom), 0);

    // Stall 33 taken results; the 33rd is dropped.
    dutDrops = 0;
    for (int i = 0; i < 33; i++)
      step(1, 1, 32'h4000 + 32'(i * 4), $urandom, 3'($urandom), 1);
    check("drop_pulses", 64'(dutDrops), 64'(1));
    for (int i = 0; i < 33; i++)
      step(0, 1, 32'h0, 32'h0, 3'b000, 0);

    // Full queue, port free, new taken result: enqueue and dequeue together.
    for (int i = 0; i < 32; i++)
      step(1, 1, 32'h8000 + 32'(i * 4), $urandom, 3'($urandom), 1);
    step(1, 1, 32'h9000, 32'h9abc, 3'b010, 0);
    step(1, 1, 32'h9004, 32'h9def, 3'b001, 0);
    for (int i = 0; i < 34; i++)
      step(0, 0, 32'h0, 32'h0, 3'b000, 0);

    // Async reset while 5 entries are queued and draining.
    for (int i = 0; i < 5; i++)
      step(1, 1, 32'hA000 + 32'(i * 4), $urandom, 3'($urandom), 1);
    brResult.valid = 1'b0;
    btbReadBusy = 1'b0;
    #2;
    check("pre_rst_we", 64'(btbWE), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_we", 64'(btbWE), 64'(0));
    check("async_rst_count", 64'(queueCount), 64'(0));
    mq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      step(0, 0, 32'h0, 32'h0, 3'b000, 0);

    // Randomized traffic with bursty read-port contention.
    for (int i = 0; i < 600; i++) begin
      logic bsy;
      bsy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 80,
           $urandom & 32'hFFFF_FFFC, $urandom, 3'($urandom), bsy);
    end
    for (int i = 0; i < 40; i++)
      step(0, 0, 32'h0, 32'h0, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
